// File: rtl/operand_packer.sv
// operand_packer: serial-to-parallel feeder for the seven-lane multiply stage.
// Collects one (weight, pixel) pair per accepted input transfer into a fill
// buffer and hands completed groups to a single output register. A completed
// group that cannot enter the output register is parked in the fill buffer
// (held), which stalls the input until the output drains.
// Optional feature macro: OPERAND_PACKER_LANE_MASK_EN adds the out_mask port.
module operand_packer #(
  parameter int unsigned LANES = 7,
  parameter int unsigned WW    = 19,
  parameter int unsigned PW    = 10
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WW-1:0]       in_weight,
  input  logic [PW-1:0]       in_pixel,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*WW-1:0] WeightX,
  output logic [LANES*PW-1:0] PixelX,
`ifdef OPERAND_PACKER_LANE_MASK_EN
  output logic [LANES-1:0]    out_mask,
`endif
  output logic                out_last
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  held_q, held_d;
  logic [LANES*WW-1:0]   fill_w_q, fill_w_d, out_w_q, out_w_d, grp_w;
  logic [LANES*PW-1:0]   fill_p_q, fill_p_d, out_p_q, out_p_d, grp_p;
  logic                  fill_last_q, fill_last_d, out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
`ifdef OPERAND_PACKER_LANE_MASK_EN
  logic [LANES-1:0]      fill_mask_q, fill_mask_d, out_mask_q, out_mask_d, grp_mask;
`endif

  logic accept, complete, drain, out_free, last_lane;

  assign accept    = in_valid & ~held_q;
  assign last_lane = (idx_q == IdxW'(LANES - 1));
  assign complete  = accept & (in_last | last_lane);
  assign drain     = out_valid_q & out_ready;
  assign out_free  = ~out_valid_q | out_ready;

  // Current group with the incoming pair merged at lane idx; lanes above idx
  // are forced to zero so a short group leaves with clean padding.
  always_comb begin
    grp_w = '0;
    grp_p = '0;
`ifdef OPERAND_PACKER_LANE_MASK_EN
    grp_mask = '0;
`endif
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k < 32'(idx_q)) begin
        grp_w[k*WW +: WW] = fill_w_q[k*WW +: WW];
        grp_p[k*PW +: PW] = fill_p_q[k*PW +: PW];
`ifdef OPERAND_PACKER_LANE_MASK_EN
        grp_mask[k] = 1'b1;
`endif
      end else if (k == 32'(idx_q)) begin
        grp_w[k*WW +: WW] = in_weight;
        grp_p[k*PW +: PW] = in_pixel;
`ifdef OPERAND_PACKER_LANE_MASK_EN
        grp_mask[k] = 1'b1;
`endif
      end
    end
  end

  // Next-state: lane fill, group hand-off to the output register, hold/release.
  always_comb begin
    idx_d       = idx_q;
    held_d      = held_q;
    fill_w_d    = fill_w_q;
    fill_p_d    = fill_p_q;
    fill_last_d = fill_last_q;
    out_w_d     = out_w_q;
    out_p_d     = out_p_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
`ifdef OPERAND_PACKER_LANE_MASK_EN
    fill_mask_d = fill_mask_q;
    out_mask_d  = out_mask_q;
`endif

    if (drain) out_valid_d = 1'b0;

    if (held_q) begin
      // Input is stalled; the parked group follows the drained one.
      if (drain) begin
        out_w_d     = fill_w_q;
        out_p_d     = fill_p_q;
        out_last_d  = fill_last_q;
        out_valid_d = 1'b1;
        held_d      = 1'b0;
`ifdef OPERAND_PACKER_LANE_MASK_EN
        out_mask_d  = fill_mask_q;
`endif
      end
    end else if (accept) begin
      if (complete) begin
        idx_d = '0;
        if (out_free) begin
          out_w_d     = grp_w;
          out_p_d     = grp_p;
          out_last_d  = in_last;
          out_valid_d = 1'b1;
`ifdef OPERAND_PACKER_LANE_MASK_EN
          out_mask_d  = grp_mask;
`endif
        end else begin
          fill_w_d    = grp_w;
          fill_p_d    = grp_p;
          fill_last_d = in_last;
          held_d      = 1'b1;
`ifdef OPERAND_PACKER_LANE_MASK_EN
          fill_mask_d = grp_mask;
`endif
        end
      end else begin
        fill_w_d = grp_w;
        fill_p_d = grp_p;
        idx_d    = idx_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any partial or held group.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      idx_q       <= '0;
      held_q      <= 1'b0;
      fill_w_q    <= '0;
      fill_p_q    <= '0;
      fill_last_q <= 1'b0;
      out_w_q     <= '0;
      out_p_q     <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef OPERAND_PACKER_LANE_MASK_EN
      fill_mask_q <= '0;
      out_mask_q  <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      held_q      <= held_d;
      fill_w_q    <= fill_w_d;
      fill_p_q    <= fill_p_d;
      fill_last_q <= fill_last_d;
      out_w_q     <= out_w_d;
      out_p_q     <= out_p_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
`ifdef OPERAND_PACKER_LANE_MASK_EN
      fill_mask_q <= fill_mask_d;
      out_mask_q  <= out_mask_d;
`endif
    end
  end

  assign in_ready  = ~held_q;
  assign out_valid = out_valid_q;
  assign WeightX   = out_w_q;
  assign PixelX    = out_p_q;
  assign out_last  = out_last_q;
`ifdef OPERAND_PACKER_LANE_MASK_EN
  assign out_mask  = out_mask_q;
`endif

endmodule
